// File: rtl/genius_game_ctrl.sv
// ---------------------------------------------------------------------------
// genius_game_ctrl
//   Round sequencer for the Genius (Simon) game. Each round appends one random
//   colour to the stored sequence, plays the whole sequence back on the LED
//   outputs, then checks the player's IR button presses against it. The game
//   ends in WIN after MAX_LEN colours are matched, or in LOSE on a mismatch.
//
// Optional feature macro: GENIUS_TIMEOUT_EN
//   defined   -> per-press deadline of TIMEOUT_CYCLES in WAIT_IN (expiry = LOSE)
//   undefined -> WAIT_IN waits indefinitely, TIMEOUT_CYCLES unused
//
// Handshake: ir_ready/ir_botao is a level-valid interface with no ready back;
//   one press is counted on each rising edge of ir_ready, and ir_botao is
//   sampled in that edge cycle. Presses outside IDLE/WAIT_IN/WIN/LOSE are
//   dropped, never queued.
//
// Ports
//   clk_pll    in   1  system clock
//   reset      in   1  synchronous, active-high reset
//   start      in   1  start/restart request (level or pulse)
//   rand_cor   in   2  free-running random colour, sampled in ADD
//   ir_ready   in   1  decoder button-valid
//   ir_botao   in   3  decoded IR button code
//   led_cor    out  2  colour being displayed
//   led_on     out  1  display enable
//   level      out  5  current sequence length
//   busy       out  1  high except in IDLE/WIN/LOSE
//   win        out  1  held high in WIN
//   game_over  out  1  held high in LOSE
//   state_dbg  out  3  current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module genius_game_ctrl #(
    parameter int          MAX_LEN        = 16,
    parameter logic [23:0] SHOW_CYCLES    = 24'd5000000,
    parameter logic [23:0] GAP_CYCLES     = 24'd2500000,
    parameter logic [27:0] TIMEOUT_CYCLES = 28'd150000000
) (
    input  logic       clk_pll,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] rand_cor,
    input  logic       ir_ready,
    input  logic [2:0] ir_botao,
    output logic [1:0] led_cor,
    output logic       led_on,
    output logic [4:0] level,
    output logic       busy,
    output logic       win,
    output logic       game_over,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADD      = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_OFF = 3'd3,
        S_WAIT_IN  = 3'd4,
        S_WIN      = 3'd5,
        S_LOSE     = 3'd6
    } state_t;

    localparam logic [4:0]  MAX_LEN5  = 5'(MAX_LEN);
    localparam logic [27:0] SHOW_LAST = 28'(SHOW_CYCLES) - 28'd1;
    localparam logic [27:0] GAP_LAST  = 28'(GAP_CYCLES) - 28'd1;

    state_t      state, state_nx;
    logic        ir_ready_q;
    logic [4:0]  len;
    logic [4:0]  idx;
    logic [27:0] timer;
    logic [1:0]  seq [MAX_LEN];

    logic        press;
    logic        key_is_col;
    logic [1:0]  key_col;
    logic        key_is_start;
    logic        go;
    logic [1:0]  cur_col;
    logic        last_idx;
    logic        show_done;
    logic        gap_done;
    logic        col_press;
    logic        hit;
    logic        timer_run;
    logic        timer_clr;

    // Rising edge of the decoder valid: a held level counts once.
    assign press        = ir_ready & ~ir_ready_q;
    assign key_is_start = (ir_botao == 3'b001);
    assign go           = start | (press & key_is_start);
    assign last_idx     = (idx == len - 5'd1);
    assign show_done    = (timer == SHOW_LAST);
    assign gap_done     = (timer == GAP_LAST);
    assign col_press    = press & key_is_col;
    assign hit          = (key_col == cur_col);
    assign level        = len;
    assign state_dbg    = state;

    // Colour key map; any other code is not a colour key.
    always_comb begin
        key_is_col = 1'b1;
        key_col    = 2'd0;
        case (ir_botao)
            3'b100:  key_col = 2'd0;
            3'b011:  key_col = 2'd1;
            3'b110:  key_col = 2'd2;
            3'b010:  key_col = 2'd3;
            default: key_is_col = 1'b0;
        endcase
    end

    // Sequence read mux at idx.
    always_comb begin
        cur_col = 2'd0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx == 5'(i)) cur_col = seq[i];
        end
    end

    // Next state and outputs.
    always_comb begin
        state_nx  = state;
        led_on    = 1'b0;
        led_cor   = 2'd0;
        win       = 1'b0;
        game_over = 1'b0;
        busy      = 1'b1;
        timer_run = 1'b0;
        timer_clr = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (go) state_nx = S_ADD;
            end
            S_ADD: begin
                state_nx = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                led_on    = 1'b1;
                led_cor   = cur_col;
                timer_run = 1'b1;
                if (show_done) state_nx = S_SHOW_OFF;
            end
            S_SHOW_OFF: begin
                timer_run = 1'b1;
                if (gap_done) state_nx = last_idx ? S_WAIT_IN : S_SHOW_ON;
            end
            S_WAIT_IN: begin
`ifdef GENIUS_TIMEOUT_EN
                timer_run = 1'b1;
`endif
                if (col_press) begin
                    if (hit) begin
                        // One-cycle echo of the accepted key.
                        led_on    = 1'b1;
                        led_cor   = key_col;
`ifdef GENIUS_TIMEOUT_EN
                        timer_clr = 1'b1;
`endif
                        if (last_idx) state_nx = (len == MAX_LEN5) ? S_WIN : S_ADD;
                    end else begin
                        state_nx = S_LOSE;
                    end
                end
`ifdef GENIUS_TIMEOUT_EN
                else if (timer == TIMEOUT_CYCLES - 28'd1) begin
                    state_nx = S_LOSE;
                end
`endif
            end
            S_WIN: begin
                busy = 1'b0;
                win  = 1'b1;
                if (go) state_nx = S_ADD;
            end
            S_LOSE: begin
                busy      = 1'b0;
                game_over = 1'b1;
                if (go) state_nx = S_ADD;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_pll) begin
        if (reset) begin
            state      <= S_IDLE;
            ir_ready_q <= 1'b0;
            len        <= '0;
            idx        <= '0;
            timer      <= '0;
            for (int i = 0; i < MAX_LEN; i++) seq[i] <= 2'd0;
        end else begin
            state      <= state_nx;
            ir_ready_q <= ir_ready;

            // Timer restarts on every state change.
            if (state_nx != state || timer_clr) timer <= '0;
            else if (timer_run)                 timer <= timer + 28'd1;

            case (state)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (go) len <= '0;
                end
                S_ADD: begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (len == 5'(i)) seq[i] <= rand_cor;
                    end
                    len <= len + 5'd1;
                    idx <= '0;
                end
                S_SHOW_OFF: begin
                    if (gap_done) idx <= last_idx ? 5'd0 : idx + 5'd1;
                end
                S_WAIT_IN: begin
                    if (col_press && hit) idx <= last_idx ? 5'd0 : idx + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
